fake_n64_controller_rx: RTL and testbench

Console-to-controller receive stage of the fake N64 controller. Oversamples the Joybus data line, decodes console bits by low-pulse width and detects the console stop bit by line idle. It captures the command byte and up to two address bytes, then grants the line to the controller transmitter through `cur_operation`. It sits directly upstream of `fake_n64_controller_tx`, which returns the line with a `rx_handoff` pulse.

---
 rtl/fake_n64_controller_rx_pkg.sv | 14 +
 rtl/fake_n64_controller_rx_if.sv | 20 ++
 rtl/fake_n64_sync2.sv | 17 +
 rtl/fake_n64_controller_rx.sv | 134 +++++++++++++
 tb/tb_fake_n64_controller_rx.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/fake_n64_controller_rx_pkg.sv
// fake_n64_controller_rx_pkg: shared Joybus timing defaults, command codes, RX states and field types
package fake_n64_controller_rx_pkg;
    localparam int DEF_LEVEL_WIDTH = 2;
    localparam int DEF_BIT_WIDTH = 4 * DEF_LEVEL_WIDTH;
    localparam logic [7:0] CMD_INFO = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_READ = 8'h02;
    localparam logic [7:0] CMD_WRITE = 8'h03;
    localparam logic [7:0] CMD_RESET = 8'hFF;
    typedef enum logic [2:0] {IDLE, LOW, HIGH, TX_WAIT, ERROR} rx_state_e;
    typedef logic [7:0] cmd_t;
    typedef logic [15:0] addr_t;
    typedef logic [5:0] cnt_t;
endpackage

// File: rtl/fake_n64_controller_rx_if.sv
// fake_n64_controller_rx_if: Joybus line, TX handoff and decoded-frame outputs of the RX stage
interface fake_n64_controller_rx_if;
    import fake_n64_controller_rx_pkg::*;
    logic data_rx;
    logic rx_handoff;
    logic cur_operation;
    cmd_t cmd;
    addr_t addr;
    cnt_t rx_byte_count;
    logic cmd_valid;
    logic frame_err;
    modport master (
        output data_rx, rx_handoff,
        input cur_operation, cmd, addr, rx_byte_count, cmd_valid, frame_err
    );
    modport slave (
        input data_rx, rx_handoff,
        output cur_operation, cmd, addr, rx_byte_count, cmd_valid, frame_err
    );
endinterface

// File: rtl/fake_n64_sync2.sv
// fake_n64_sync2: two-flop synchronizer for an asynchronous pin, idling high out of reset
module fake_n64_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [1:0] sync_q;
    logic [1:0] sync_d;
    // shift the pin through two flops
    always_comb sync_d = {sync_q[0], d};
    // synchronizer flops reset to the idle-high line level
    always_ff @(posedge clk or posedge reset)
        if (reset) sync_q <= 2'b11;
        else sync_q <= sync_d;
    assign q = sync_q[1];
endmodule

// File: rtl/fake_n64_controller_rx.sv
// fake_n64_controller_rx: decodes console Joybus frames by low-pulse width and hands the line to TX
module fake_n64_controller_rx
    import fake_n64_controller_rx_pkg::*;
#(
    parameter int LEVEL_WIDTH = DEF_LEVEL_WIDTH
) (
    input logic clk,
    input logic reset,
    fake_n64_controller_rx_if.slave bus
);
    localparam int BIT_WIDTH = 4 * LEVEL_WIDTH;
    localparam cnt_t ONE_THR = cnt_t'(2 * LEVEL_WIDTH);
    localparam cnt_t IDLE_THR = cnt_t'(BIT_WIDTH);
    localparam cnt_t ABORT_THR = cnt_t'(2 * BIT_WIDTH);

    logic line;
    logic line_d_q;
    cnt_t lvl_cnt_q, lvl_cnt_d;
    rx_state_e state_q, state_d;
    logic [6:0] shift_q, shift_d;
    logic [2:0] bit_in_byte_q, bit_in_byte_d;
    cnt_t byte_cnt_q, byte_cnt_d;
    cmd_t cmd_stg_q, cmd_stg_d;
    addr_t addr_stg_q, addr_stg_d;
    cmd_t cmd_q, cmd_d;
    addr_t addr_q, addr_d;
    cnt_t count_q, count_d;
    logic cmd_valid_q, cmd_valid_d;
    logic frame_err_q, frame_err_d;
    logic fall, rise, bit_val, frame_ok;
    logic [7:0] byte_val;

    fake_n64_sync2 u_sync (.clk(clk), .reset(reset), .d(bus.data_rx), .q(line));

    // edge detect, level counter and bit decode helpers
    always_comb begin
        fall = line_d_q & ~line;
        rise = ~line_d_q & line;
        lvl_cnt_d = (fall | rise) ? '0 : (&lvl_cnt_q) ? lvl_cnt_q : lvl_cnt_q + cnt_t'(1);
        bit_val = lvl_cnt_q < ONE_THR;
        byte_val = {shift_q, bit_val};
        frame_ok = (bit_in_byte_q == 3'd1) && shift_q[0] && (byte_cnt_q != '0);
    end

    // frame FSM: bit shifting, byte staging and frame-end checks
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_in_byte_d = bit_in_byte_q;
        byte_cnt_d = byte_cnt_q;
        cmd_stg_d = cmd_stg_q;
        addr_stg_d = addr_stg_q;
        cmd_d = cmd_q;
        addr_d = addr_q;
        count_d = count_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: if (fall) begin
                state_d = LOW;
                shift_d = '0;
                bit_in_byte_d = '0;
                byte_cnt_d = '0;
                cmd_stg_d = '0;
                addr_stg_d = '0;
            end
            LOW: if (lvl_cnt_q >= ABORT_THR) begin
                frame_err_d = 1'b1;
                state_d = ERROR;
            end else if (rise) begin
                shift_d = byte_val[6:0];
                bit_in_byte_d = bit_in_byte_q + 3'd1;
                state_d = HIGH;
                if (bit_in_byte_q == 3'd7) begin
                    if (byte_cnt_q == cnt_t'(0)) cmd_stg_d = byte_val;
                    if (byte_cnt_q == cnt_t'(1)) addr_stg_d[15:8] = byte_val;
                    if (byte_cnt_q == cnt_t'(2)) addr_stg_d[7:0] = byte_val;
                    byte_cnt_d = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + cnt_t'(1);
                end
            end
            HIGH: if (fall) state_d = LOW;
            else if (lvl_cnt_q >= IDLE_THR) begin
                state_d = frame_ok ? TX_WAIT : IDLE;
                cmd_valid_d = frame_ok;
                frame_err_d = ~frame_ok;
                cmd_d = frame_ok ? cmd_stg_q : cmd_q;
                addr_d = frame_ok ? addr_stg_q : addr_q;
                count_d = frame_ok ? byte_cnt_q : count_q;
            end
            TX_WAIT: if (bus.rx_handoff) state_d = IDLE;
            ERROR: if (line && line_d_q && lvl_cnt_q >= IDLE_THR) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            line_d_q <= 1'b1;
            lvl_cnt_q <= '0;
            state_q <= IDLE;
            shift_q <= '0;
            bit_in_byte_q <= '0;
            byte_cnt_q <= '0;
            cmd_stg_q <= '0;
            addr_stg_q <= '0;
            cmd_q <= '0;
            addr_q <= '0;
            count_q <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            line_d_q <= line;
            lvl_cnt_q <= lvl_cnt_d;
            state_q <= state_d;
            shift_q <= shift_d;
            bit_in_byte_q <= bit_in_byte_d;
            byte_cnt_q <= byte_cnt_d;
            cmd_stg_q <= cmd_stg_d;
            addr_stg_q <= addr_stg_d;
            cmd_q <= cmd_d;
            addr_q <= addr_d;
            count_q <= count_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
        end

    assign bus.cur_operation = (state_q == TX_WAIT);
    assign bus.cmd = cmd_q;
    assign bus.addr = addr_q;
    assign bus.rx_byte_count = count_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_fake_n64_controller_rx.sv
// tb_fake_n64_controller_rx: scoreboard bench driving Joybus frames against a frame-level reference model
module tb_fake_n64_controller_rx;
    import fake_n64_controller_rx_pkg::*;
    localparam int LW = DEF_LEVEL_WIDTH;
    localparam int BW = 4 * LW;

    typedef struct {
        logic valid;
        logic [7:0] cmd;
        logic [15:0] addr;
        logic [5:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    exp_t exp_q[$];
    logic [7:0] fb[$];
    logic [7:0] m_cmd = 8'h00;
    logic [15:0] m_addr = 16'h0000;
    logic [5:0] m_cnt = 6'd0;

    fake_n64_controller_rx_if bus ();
    fake_n64_controller_rx #(.LEVEL_WIDTH(LW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: every output pulse consumes one expected frame outcome
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.cmd_valid || bus.frame_err) begin
                if (exp_q.size() == 0) check("unexpected_pulse", {bus.cmd_valid, bus.frame_err}, 0);
                else begin
                    e = exp_q.pop_front();
                    check("cmd_valid", bus.cmd_valid, e.valid);
                    check("frame_err", bus.frame_err, !e.valid);
                    check("cmd", bus.cmd, e.cmd);
                    check("addr", bus.addr, e.addr);
                    check("rx_byte_count", bus.rx_byte_count, e.cnt);
                    check("cur_operation_at_pulse", bus.cur_operation, e.valid);
                end
            end
        end
    end

    task automatic drive(input logic v, input int n);
        bus.data_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        drive(1'b0, b ? LW : 3 * LW);
        drive(1'b1, b ? 3 * LW : LW);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("pulse_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic handoff();
        bus.data_rx = 1'b1;
        repeat (4) @(negedge clk);
        check("cur_operation_tx", bus.cur_operation, 1);
        bus.rx_handoff = 1'b1;
        @(negedge clk);
        bus.rx_handoff = 1'b0;
        check("cur_operation_rx", bus.cur_operation, 0);
    endtask

    task automatic push_outcome(input logic valid);
        exp_t e;
        e.valid = valid;
        e.cmd = m_cmd;
        e.addr = m_addr;
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    // a frame is valid exactly when whole bytes (at least one) precede the stop bit
    task automatic send_frame(input int nbits, input bit toggle);
        logic valid;
        logic [7:0] by;
        valid = (nbits % 8 == 0) && (nbits >= 8);
        if (valid) begin
            m_cmd = fb[0];
            m_addr = {nbits >= 16 ? fb[1] : 8'h00, nbits >= 24 ? fb[2] : 8'h00};
            m_cnt = (nbits / 8 > 63) ? 6'd63 : 6'(nbits / 8);
        end
        push_outcome(valid);
        for (int i = 0; i < nbits; i++) begin
            by = fb[i / 8];
            send_bit(by[7 - (i % 8)]);
        end
        drive(1'b0, LW);
        drive(1'b1, 3 * BW);
        drain();
        if (valid) begin
            if (toggle) for (int i = 0; i < 40; i++) begin
                bus.data_rx = 1'($urandom);
                @(negedge clk);
            end
            handoff();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cur_operation"}, bus.cur_operation, 0);
        check({tag, "_cmd"}, bus.cmd, 0);
        check({tag, "_addr"}, bus.addr, 0);
        check({tag, "_rx_byte_count"}, bus.rx_byte_count, 0);
        check({tag, "_cmd_valid"}, bus.cmd_valid, 0);
        check({tag, "_frame_err"}, bus.frame_err, 0);
    endtask

    initial begin
        int nbytes;
        int nbits;
        bus.data_rx = 1'b1;
        bus.rx_handoff = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        fb = '{CMD_INFO};
        send_frame(8, 1'b0);
        fb = '{CMD_READ, 8'h80, 8'h01};
        send_frame(24, 1'b0);
        fb = '{8'h05};
        send_frame(7, 1'b0);
        check("cur_operation_after_err", bus.cur_operation, 0);
        push_outcome(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        drive(1'b0, 20);
        drive(1'b1, 30);
        drain();
        fb = '{CMD_STATUS};
        send_frame(8, 1'b0);
        fb = '{CMD_WRITE, 8'h12, 8'h34, 8'h56};
        send_frame(32, 1'b1);
        fb = '{CMD_RESET};
        send_frame(8, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        drive(1'b0, 3);
        #2 reset = 1'b1;
        bus.data_rx = 1'b1;
        #1 check_reset_outputs("midframe_reset");
        m_cmd = 8'h00;
        m_addr = 16'h0000;
        m_cnt = 6'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        fb = '{CMD_STATUS};
        send_frame(8, 1'b0);
        for (int f = 0; f < 12; f++) begin
            fb.delete();
            nbytes = $urandom_range(1, 4);
            for (int i = 0; i < nbytes; i++) fb.push_back(8'($urandom));
            nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nbytes * 8 - 1) : nbytes * 8;
            send_frame(nbits, 1'($urandom_range(0, 1)));
        end
        repeat (20) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
